// File: rtl/ternary_op_scheduler.sv
// Round-robin scheduler feeding one trit-serial ternary unit (min/max/any/consensus).
// Optional TRIT_CHECK_EN flags invalid trit codes (11) via rsp_err.
module ternary_op_scheduler #(
   parameter  int N_REQ   = 2,
   parameter  int N_TRITS = 8,
   localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int W       = 2 * N_TRITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [2*N_REQ-1:0]   req_op,
   input  logic [W*N_REQ-1:0]   req_a,
   input  logic [W*N_REQ-1:0]   req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [W-1:0]         rsp_data,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam int IDX_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  rr_q, rr_d, id_q, id_d;
   logic [1:0]       op_q, op_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             grant_vld;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W:0]    cand;
   logic [1:0]       sel_op;
   logic [W-1:0]     sel_a, sel_b;
   logic [1:0]       ta, tb, tr;
   logic             bad;

   // Only bit1 means "high", so an unchecked 11 code evaluates as 2.
   function automatic logic [1:0] trit_eval(input logic [1:0] op, input logic [1:0] a,
                                            input logic [1:0] b);
      logic [1:0] va, vb, r;
      va = a[1] ? 2'd2 : {1'b0, a[0]};
      vb = b[1] ? 2'd2 : {1'b0, b[0]};
      case (op)
         2'd0:    r = (va < vb) ? va : vb;
         2'd1:    r = (va > vb) ? va : vb;
         2'd2:    r = (va == vb) ? va : (va == 2'd1) ? vb : (vb == 2'd1) ? va : 2'd1;
         default: r = (va == vb) ? va : 2'd1;
      endcase
      return r;
   endfunction

   // Descending scan so the requester closest to the pointer is the last (winning) hit.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
         for (int r = 0; r < N_REQ; r++) begin
            if (cand == (ID_W+1)'(r) && req_valid[r]) begin
               grant_vld = 1'b1;
               grant_id  = ID_W'(r);
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int r = 0; r < N_REQ; r++) begin
         if (grant_id == ID_W'(r)) begin
            req_ready[r] = (state_q == IDLE) && grant_vld;
            sel_op       = req_op[2*r +: 2];
            sel_a        = req_a[r*W +: W];
            sel_b        = req_b[r*W +: W];
         end
      end
   end

   always_comb begin
      ta = '0;
      tb = '0;
      for (int i = 0; i < N_TRITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            ta = a_q[2*i +: 2];
            tb = b_q[2*i +: 2];
         end
      end
   end

`ifdef TRIT_CHECK_EN
   logic err_q, err_d;
   assign bad     = (&ta) | (&tb);
   assign tr      = bad ? 2'b00 : trit_eval(op_q, ta, tb);
   assign rsp_err = err_q;
`else
   assign bad     = 1'b0;
   assign tr      = trit_eval(op_q, ta, tb);
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      idx_d   = idx_q;
`ifdef TRIT_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               op_d    = sel_op;
               a_d     = sel_a;
               b_d     = sel_b;
               id_d    = grant_id;
               idx_d   = '0;
               state_d = RUN;
`ifdef TRIT_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         RUN: begin
            for (int i = 0; i < N_TRITS; i++) begin
               if (idx_q == IDX_W'(i)) res_d[2*i +: 2] = tr;
            end
`ifdef TRIT_CHECK_EN
            if (bad) err_d = 1'b1;
`endif
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(N_TRITS - 1)) begin
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
               rr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         idx_q   <= '0;
`ifdef TRIT_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         idx_q   <= idx_d;
`ifdef TRIT_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign rsp_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign rsp_id    = id_q;
   assign rsp_data  = res_q;

endmodule

// File: tb/tb_ternary_op_scheduler.sv
// Self-checking bench: table vectors, hand-written corner sequences and random jobs
// checked against a value-level ternary model and a round-robin pointer model.
module tb_ternary_op_scheduler;
   localparam int N_REQ   = 2;
   localparam int N_TRITS = 4;
   localparam int W       = 2 * N_TRITS;

   logic                 clk;
   logic                 rst_n;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_ready;
   logic [2*N_REQ-1:0]   req_op;
   logic [W*N_REQ-1:0]   req_a;
   logic [W*N_REQ-1:0]   req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [0:0]           rsp_id;
   logic [W-1:0]         rsp_data;
   logic                 rsp_err;
   logic                 busy;

   int n_cmp = 0;
   int n_bad = 0;
   int rr_m  = 0;

   ternary_op_scheduler #(.N_REQ(N_REQ), .N_TRITS(N_TRITS)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int         r;
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Words written MSB trit first, as in the documentation.
   function automatic logic [7:0] tw(input int d3, input int d2, input int d1, input int d0);
      return {2'(d3), 2'(d2), 2'(d1), 2'(d0)};
   endfunction

   // Value-level model: trits as integers, "any" as a clamped balanced sum.
   function automatic void ref_job(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b, output logic [7:0] d, output logic e);
      int ta, tb, va, vb, vr, s;
      d = '0;
      e = 1'b0;
      for (int i = 0; i < N_TRITS; i++) begin
         ta = int'(a[2*i +: 2]);
         tb = int'(b[2*i +: 2]);
         va = (ta == 3) ? 2 : ta;
         vb = (tb == 3) ? 2 : tb;
         case (op)
            2'd0: vr = (va < vb) ? va : vb;
            2'd1: vr = (va > vb) ? va : vb;
            2'd2: begin
               s = (va - 1) + (vb - 1);
               if (s > 1) s = 1;
               if (s < -1) s = -1;
               vr = s + 1;
            end
            default: vr = (va == vb) ? va : 1;
         endcase
`ifdef TRIT_CHECK_EN
         if (ta == 3 || tb == 3) begin
            vr = 0;
            e  = 1'b1;
         end
`endif
         d[2*i +: 2] = 2'(vr);
      end
   endfunction

   function automatic logic [15:0] rnd_words();
      logic [15:0] w;
      int t;
      w = '0;
      for (int i = 0; i < 2 * N_TRITS; i++) begin
         t = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         w[2*i +: 2] = 2'(t);
      end
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_job(input logic [1:0] mask, input logic [3:0] ops, input logic [15:0] aa,
                         input logic [15:0] bb, input int hold, input bit drop, input bit rnd_rdy,
                         output logic [7:0] gd, output logic [0:0] gid, output logic ge);
      int g, n, c;
      logic [7:0] ed, sd;
      logic ee;
      g = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         c = (rr_m + k) % N_REQ;
         if (mask[c]) g = c;
      end
      req_valid = mask;
      req_op    = ops;
      req_a     = aa;
      req_b     = bb;
      #1;
      chk("grant", 32'(req_ready), 32'(1 << g));
      ref_job(ops[2*g +: 2], aa[8*g +: 8], bb[8*g +: 8], ed, ee);
      step();
      if (drop) req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         chk("run_ready", 32'(req_ready), 0);
         chk("run_busy", 32'(busy), 1);
         if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      rsp_ready = 1'b0;
      chk("latency", n, N_TRITS);
      chk("data", 32'(rsp_data), 32'(ed));
      chk("id", 32'(rsp_id), g);
      chk("err", 32'(rsp_err), 32'(ee));
      sd  = rsp_data;
      gd  = rsp_data;
      gid = rsp_id;
      ge  = rsp_err;
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_valid", 32'(rsp_valid), 1);
         chk("hold_data", 32'(rsp_data), 32'(sd));
         chk("hold_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("release", 32'({rsp_valid, busy}), 0);
      rr_m = (g + 1) % N_REQ;
   endtask

   initial begin
      logic [7:0]  gd;
      logic [0:0]  gid;
      logic        ge;
      logic [15:0] aa, bb;
      logic [3:0]  ops;
      logic [1:0]  mask;

      tbl[0] = '{0, 2'd0, tw(2,1,0,2), tw(1,1,2,0), tw(1,1,0,0)};
      tbl[1] = '{0, 2'd1, tw(2,1,0,2), tw(1,1,2,0), tw(2,1,2,2)};
      tbl[2] = '{0, 2'd2, tw(2,1,0,2), tw(1,1,2,0), tw(2,1,1,1)};
      tbl[3] = '{0, 2'd3, tw(2,1,0,2), tw(1,1,2,0), tw(1,1,1,1)};
      tbl[4] = '{1, 2'd3, tw(2,2,0,1), tw(2,0,0,2), tw(2,1,0,1)};
      tbl[5] = '{1, 2'd2, tw(0,0,1,2), tw(2,0,2,2), tw(1,0,2,2)};

      rst_n     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", 32'(rsp_data), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_err", 32'(rsp_err), 0);
      chk("rst_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      step();
      chk("idle_ready", 32'(req_ready), 0);

      for (int i = 0; i < 6; i++) begin
         aa  = rnd_words();
         bb  = rnd_words();
         ops = 4'($urandom);
         aa[8*tbl[i].r +: 8]  = tbl[i].a;
         bb[8*tbl[i].r +: 8]  = tbl[i].b;
         ops[2*tbl[i].r +: 2] = tbl[i].op;
         do_job(2'(1 << tbl[i].r), ops, aa, bb, 0, 1'b1, 1'b0, gd, gid, ge);
         chk("tbl_data", 32'(gd), 32'(tbl[i].exp));
         chk("tbl_id", 32'(gid), tbl[i].r);
      end

      // Both valid continuously: grants alternate, long stall in DONE.
      for (int i = 0; i < 4; i++) begin
         do_job(2'b11, 4'($urandom), rnd_words(), rnd_words(), (i == 1) ? 10 : 0, 1'b0,
                1'b1, gd, gid, ge);
         chk("alt_id", 32'(gid), i % 2);
      end

      // Mid-RUN reset: pointer is 1 after the r0 job, then r1 is aborted at idx 2.
      do_job(2'b01, 4'($urandom), rnd_words(), rnd_words(), 0, 1'b1, 1'b0, gd, gid, ge);
      req_valid = 2'b10;
      req_a     = rnd_words();
      req_b     = rnd_words();
      #1;
      chk("pre_abort_grant", 32'(req_ready), 2);
      step();
      step();
      step();
      chk("pre_abort_busy", 32'(busy), 1);
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      chk("abort_out", 32'({req_ready, rsp_valid, busy, rsp_err, rsp_id, rsp_data}), 0);
      step();
      rst_n = 1'b1;
      rr_m  = 0;
      step();
      do_job(2'b11, 4'($urandom), rnd_words(), rnd_words(), 0, 1'b1, 1'b0, gd, gid, ge);
      chk("abort_ptr", 32'(gid), 0);
      do_job(2'b10, 4'($urandom), rnd_words(), rnd_words(), 0, 1'b1, 1'b0, gd, gid, ge);
      chk("abort_r1", 32'(gid), 1);

`ifdef TRIT_CHECK_EN
      do_job(2'b01, 4'b0000, {8'h00, tw(2,3,1,2)}, {8'h00, tw(0,0,0,0)}, 0, 1'b1, 1'b0,
             gd, gid, ge);
      chk("inv_err", 32'(ge), 1);
      chk("inv_data", 32'(gd), 0);
      do_job(2'b10, 4'b0000, {tw(1,1,1,1), 8'h00}, {tw(2,2,2,2), 8'h00}, 0, 1'b1, 1'b0,
             gd, gid, ge);
      chk("clr_err", 32'(ge), 0);
      chk("clr_data", 32'(gd), 32'(tw(1,1,1,1)));
`else
      do_job(2'b01, 4'b0001, {8'h00, tw(3,0,1,3)}, {8'h00, tw(1,1,1,1)}, 0, 1'b1, 1'b0,
             gd, gid, ge);
      chk("inv_as_high", 32'(gd), 32'(tw(2,1,1,2)));
      chk("inv_no_err", 32'(ge), 0);
`endif

      for (int i = 0; i < 40; i++) begin
         mask = 2'($urandom_range(1, 3));
         do_job(mask, 4'($urandom), rnd_words(), rnd_words(), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b1, gd, gid, ge);
      end

      req_valid = '0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
